// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the 4-bit ALU: reads operands from a 4-entry register file,
// drives the ALU, then writes the result back and updates the {Z,N,C,V} flags.
module alu_issue_ctrl #(
  parameter int          NUM_REGS    = 4,
  parameter int          EXEC_WAIT   = 1,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] instr,
  input  logic       ld_en,
  input  logic [1:0] ld_addr,
  input  logic [3:0] ld_data,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [3:0] alu_c,
  input  logic [3:0] alu_cond,
  output logic [3:0] flags,
  output logic       done,
  output logic       illegal,
  input  logic [1:0] rf_addr,
  output logic [3:0] rf_data
);

  localparam int CW = (EXEC_WAIT > 1) ? $clog2(EXEC_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(EXEC_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    EXEC = 3'd2,
    WB   = 3'd3,
    REJ  = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [7:0]      instr_r;
  logic [CW-1:0]   wait_cnt_r;
  logic [3:0]      regs_r [NUM_REGS];
  logic [3:0]      op_s;
  logic [1:0]      rd_s;
  logic [1:0]      rs_s;
  logic            accept_s;
  logic            in_illegal_s;
  logic [1:0]      cv_nxt_s;

  assign op_s         = instr_r[7:4];
  assign rd_s         = instr_r[3:2];
  assign rs_s         = instr_r[1:0];
  assign instr_ready  = (state_r == IDLE);
  assign accept_s     = instr_valid && (state_r == IDLE);
  assign in_illegal_s = (instr[7:4] == 4'b1000) || (instr[7:4] == 4'b1111);
  assign rf_data      = regs_r[rf_addr];

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (in_illegal_s) begin
            state_nxt_s = REJ;
          end else begin
            state_nxt_s = READ;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ: state_nxt_s = EXEC;
      EXEC: begin
        if (wait_cnt_r == {CW{1'b0}}) begin
          state_nxt_s = WB;
        end else begin
          state_nxt_s = EXEC;
        end
      end
      WB:      state_nxt_s = IDLE;
      REJ:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Only ADD/SUB update carry and overflow
  always_comb begin
    cv_nxt_s = flags[1:0];
    if ((op_s == 4'b0001) || (op_s == 4'b0010)) begin
      cv_nxt_s = alu_cond[1:0];
    end else begin
      cv_nxt_s = flags[1:0];
    end
  end

  // State, latched instruction and exec wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      instr_r    <= 8'h00;
      wait_cnt_r <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        instr_r <= instr;
      end
      if (state_r == READ) begin
        wait_cnt_r <= WAIT_LOAD;
      end else if ((state_r == EXEC) && (wait_cnt_r != {CW{1'b0}})) begin
        wait_cnt_r <= wait_cnt_r - {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // ALU drive: operands captured at the end of READ, held until back in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= 4'h0;
      alu_b   <= 4'h0;
      alu_op  <= 4'h0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done    <= (state_nxt_s == WB) && (state_r != WB);
      illegal <= (state_nxt_s == REJ) && (state_r != REJ);
      if (state_r == READ) begin
        alu_a  <= regs_r[rd_s];
        alu_b  <= regs_r[rs_s];
        alu_op <= op_s;
      end else if (state_nxt_s == IDLE) begin
        alu_a  <= 4'h0;
        alu_b  <= 4'h0;
        alu_op <= 4'h0;
      end
    end
  end

  // Register file: write-back has priority over the load port on the same entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= 4'h0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if ((state_r == WB) && (rd_s == 2'(i))) begin
          regs_r[i] <= alu_c;
        end else if (ld_en && (ld_addr == 2'(i))) begin
          regs_r[i] <= ld_data;
        end
      end
    end
  end

  // Flags register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= RESET_FLAGS;
    end else if (state_r == WB) begin
      flags <= {alu_cond[3:2], cv_nxt_s};
    end
  end

endmodule
